// File: rtl/fp_cmp_cond_unit.sv
// fp_cmp_cond_unit: evaluates a compare predicate from FP96 compare flags, raises NV,
// and returns tagged results through a 2-entry output FIFO with sticky flags and an NV counter.
module fp_cmp_cond_unit #(
  parameter int TAGW = 8,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     in_flags,
  input  logic            in_snan,
  input  logic [3:0]      in_cond,
  input  logic            in_sig,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_res,
  output logic            out_nv,
  output logic            out_ill,
  output logic [TAGW-1:0] out_tag,
  output logic            nv_sticky,
  output logic            ill_sticky,
  input  logic            sticky_clr,
  output logic [CNTW-1:0] nv_count
);
  localparam int PW = TAGW + 3;
  logic [PW-1:0]   mem_q [2];
  logic [1:0]      cnt_q, cnt_d;
  logic            wr_q, wr_d, rd_q, rd_d;
  logic            nv_st_q, nv_st_d, ill_st_q, ill_st_d;
  logic [CNTW-1:0] nv_cnt_q, nv_cnt_d;
  logic            ill, rel, res, nv, push, pop, nv_ev;
  // Reserved codes are 5-7 and 13-15; relational codes are 1,2,9,10.
  assign ill   = in_cond[2] & (in_cond[1] | in_cond[0]);
  assign rel   = ~in_cond[2] & (in_cond[1] ^ in_cond[0]);
  assign res   = ~ill & in_flags[in_cond];
  assign nv    = in_snan | (in_sig & in_flags[4] & rel);
  assign in_ready  = cnt_q != 2'd2;
  assign out_valid = cnt_q != 2'd0;
  assign push  = in_valid & in_ready & ~flush;
  assign pop   = out_valid & out_ready & ~flush;
  assign nv_ev = push & nv;
  always_comb begin
    cnt_d    = flush ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
    wr_d     = flush ? 1'b0 : wr_q ^ push;
    rd_d     = flush ? 1'b0 : rd_q ^ pop;
    nv_st_d  = nv_ev | (nv_st_q & ~sticky_clr);
    ill_st_d = (push & ill) | (ill_st_q & ~sticky_clr);
    nv_cnt_d = sticky_clr ? CNTW'(nv_ev) : (nv_ev && !(&nv_cnt_q)) ? nv_cnt_q + CNTW'(1) : nv_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      nv_st_q  <= 1'b0;
      ill_st_q <= 1'b0;
      nv_cnt_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      if (push) mem_q[wr_q] <= {res, nv, ill, in_tag};
      nv_st_q  <= nv_st_d;
      ill_st_q <= ill_st_d;
      nv_cnt_q <= nv_cnt_d;
    end
  end
  assign {out_res, out_nv, out_ill, out_tag} = mem_q[rd_q];
  assign nv_sticky  = nv_st_q;
  assign ill_sticky = ill_st_q;
  assign nv_count   = nv_cnt_q;
endmodule

// File: tb/tb_fp_cmp_cond_unit.sv
// tb_fp_cmp_cond_unit: table-driven predicate vectors plus directed FIFO, sticky, flush and reset sequences.
module tb_fp_cmp_cond_unit;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_snan = 0, in_sig = 0;
  logic out_ready = 0, sticky_clr = 0;
  logic [15:0] in_flags = '0;
  logic [3:0] in_cond = '0;
  logic [7:0] in_tag = '0;
  logic in_ready, out_valid, out_res, out_nv, out_ill, nv_sticky, ill_sticky;
  logic [7:0] out_tag;
  logic [15:0] nv_count;
  int checks = 0, errors = 0;

  fp_cmp_cond_unit #(.TAGW(8), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_flags(in_flags), .in_snan(in_snan), .in_cond(in_cond), .in_sig(in_sig), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_nv(out_nv),
    .out_ill(out_ill), .out_tag(out_tag), .nv_sticky(nv_sticky), .ill_sticky(ill_sticky),
    .sticky_clr(sticky_clr), .nv_count(nv_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] flags;
    logic [3:0]  cond;
    logic        sig;
    logic        snan;
    logic [7:0]  tag;
    logic        res;
    logic        nv;
    logic        ill;
  } vec_t;
  vec_t tbl[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic req(input logic [15:0] f, input logic [3:0] c, input logic s, input logic sn, input logic [7:0] t);
    in_valid = 1; in_flags = f; in_cond = c; in_sig = s; in_snan = sn; in_tag = t;
  endtask

  initial begin
    int exp_nv;
    logic exp_ill;
    tbl[0]  = '{16'h1E0E, 4'd1,  1'b0, 1'b0, 8'h21, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{16'h0910, 4'd1,  1'b1, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{16'h0910, 4'd1,  1'b0, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{16'h0001, 4'd0,  1'b0, 1'b1, 8'h24, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{16'hFFFF, 4'd6,  1'b0, 1'b0, 8'h25, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{16'h1600, 4'd10, 1'b1, 1'b0, 8'h26, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{16'h0910, 4'd4,  1'b1, 1'b0, 8'h27, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{16'h0910, 4'd9,  1'b1, 1'b0, 8'h28, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{16'hFFFF, 4'd15, 1'b1, 1'b0, 8'h29, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{16'h1600, 4'd12, 1'b1, 1'b0, 8'h2A, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{16'h0008, 4'd3,  1'b1, 1'b0, 8'h2B, 1'b1, 1'b0, 1'b0};

    step(); step();
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst out_fields", {out_res, out_nv, out_ill, out_tag}, 0);
    chk("rst stickies", {nv_sticky, ill_sticky}, 0);
    chk("rst nv_count", nv_count, 0);
    rst_n = 1;
    step();

    exp_nv = 0; exp_ill = 0;
    out_ready = 1;
    foreach (tbl[i]) begin
      req(tbl[i].flags, tbl[i].cond, tbl[i].sig, tbl[i].snan, tbl[i].tag);
      step();
      in_valid = 0;
      exp_nv += int'(tbl[i].nv);
      exp_ill |= tbl[i].ill;
      chk($sformatf("vec%0d valid", i), out_valid, 1);
      chk($sformatf("vec%0d res", i), out_res, tbl[i].res);
      chk($sformatf("vec%0d nv", i), out_nv, tbl[i].nv);
      chk($sformatf("vec%0d ill", i), out_ill, tbl[i].ill);
      chk($sformatf("vec%0d tag", i), out_tag, tbl[i].tag);
      chk($sformatf("vec%0d nv_count", i), nv_count, exp_nv);
      chk($sformatf("vec%0d nv_sticky", i), nv_sticky, exp_nv != 0);
      chk($sformatf("vec%0d ill_sticky", i), ill_sticky, exp_ill);
      step();
      chk($sformatf("vec%0d drained", i), out_valid, 0);
    end

    out_ready = 0;
    req(16'h0, 4'd0, 0, 0, 8'd1);
    step();
    chk("bp 1 in_ready", in_ready, 1);
    req(16'h0, 4'd0, 0, 0, 8'd2);
    step();
    chk("bp full in_ready", in_ready, 0);
    chk("bp head tag1", out_tag, 1);
    req(16'h0, 4'd0, 0, 0, 8'd3);
    step();
    chk("bp held in_ready", in_ready, 0);
    chk("bp held head", out_tag, 1);
    out_ready = 1;
    step();
    chk("bp pop head tag2", out_tag, 2);
    chk("bp pop in_ready", in_ready, 1);
    step();
    chk("bp pushpop head tag3", out_tag, 3);
    chk("bp pushpop valid", out_valid, 1);
    chk("bp pushpop in_ready", in_ready, 1);
    in_valid = 0;
    step();
    chk("bp drained", out_valid, 0);

    sticky_clr = 1;
    req(16'h0, 4'd0, 0, 1, 8'h40);
    step();
    sticky_clr = 0; in_valid = 0;
    chk("clr+set nv_sticky", nv_sticky, 1);
    chk("clr+set nv_count", nv_count, 1);
    chk("clr ill_sticky", ill_sticky, 0);
    sticky_clr = 1;
    step();
    sticky_clr = 0;
    chk("clr nv_sticky", nv_sticky, 0);
    chk("clr nv_count", nv_count, 0);

    req(16'h0, 4'd0, 0, 1, 8'h41);
    repeat (65535) @(posedge clk);
    #1;
    in_valid = 0;
    chk("sat reach", nv_count, 16'hFFFF);
    in_valid = 1;
    repeat (3) step();
    in_valid = 0;
    chk("sat hold", nv_count, 16'hFFFF);
    sticky_clr = 1;
    step();
    sticky_clr = 0;
    chk("sat clr", nv_count, 0);

    out_ready = 0;
    req(16'h0, 4'd0, 0, 0, 8'h50);
    step();
    req(16'h0, 4'd0, 0, 0, 8'h51);
    step();
    chk("fl full", in_ready, 0);
    flush = 1; out_ready = 1;
    req(16'h0, 4'd0, 0, 1, 8'h52);
    step();
    flush = 0; in_valid = 0;
    chk("fl out_valid", out_valid, 0);
    chk("fl in_ready", in_ready, 1);
    chk("fl nv_count", nv_count, 0);
    chk("fl nv_sticky", nv_sticky, 0);
    step();
    chk("fl dropped", out_valid, 0);

    out_ready = 0;
    req(16'hFFFF, 4'd6, 0, 1, 8'h55);
    step();
    chk("mid pre valid", out_valid, 1);
    chk("mid pre ill_sticky", ill_sticky, 1);
    rst_n = 0;
    req(16'h0, 4'd0, 0, 1, 8'h56);
    step();
    rst_n = 1; in_valid = 0;
    chk("mid rst valid", out_valid, 0);
    chk("mid rst in_ready", in_ready, 1);
    chk("mid rst fields", {out_res, out_nv, out_ill, out_tag}, 0);
    chk("mid rst stickies", {nv_sticky, ill_sticky}, 0);
    chk("mid rst nv_count", nv_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
